// File: rtl/pipelined_addsub_if.sv
// Operand/result bus with valid/ready handshake for the pipelined adder/subtractor.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             sub_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output a_i, b_i, carry_i, sub_i, valid_i, ready_i,
    input  ready_o, sum_o, carry_o, overflow_o, zero_o, valid_o
  );

  modport slave (
    input  a_i, b_i, carry_i, sub_i, valid_i, ready_i,
    output ready_o, sum_o, carry_o, overflow_o, zero_o, valid_o
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: carry chain split into STAGES registered segments,
// skewed operands, signed-overflow/zero flags, stall-on-backpressure handshake.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEG1 = SEG + 1;

  logic              w_stall;
  logic              w_adv;
  logic              w_ready;
  logic              w_accept;
  logic              w_cin0;
  logic [WIDTH-1:0]  w_b_eff;
  logic [STAGES-1:0] r_valid;

  assign w_stall  = r_valid[STAGES-1] && !bus.ready_i;
  assign w_adv    = !w_stall;
  assign w_ready  = !w_stall && !rst_i;
  assign w_accept = bus.valid_i && w_ready;
  assign w_b_eff  = bus.sub_i ? ~bus.b_i : bus.b_i;
  assign w_cin0   = bus.sub_i | bus.carry_i;

  // Beat valid bits shift one stage per non-stalled cycle; bubbles are kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= w_accept;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DONE = (k + 1) * SEG;    // sum bits complete after this stage
    localparam int unsigned REM  = WIDTH - k * SEG;  // operand bits still to be added

    logic [REM-1:0]  w_a_rem;
    logic [REM-1:0]  w_b_rem;
    logic            w_cin;
    logic [SEG:0]    w_seg;
    logic [DONE-1:0] w_sum_nxt;
    logic [DONE-1:0] r_sum;
    logic            r_carry;

    if (k == 0) begin : g_in
      assign w_a_rem   = bus.a_i;
      assign w_b_rem   = w_b_eff;
      assign w_cin     = w_cin0;
      assign w_sum_nxt = w_seg[SEG-1:0];
    end else begin : g_in
      assign w_a_rem   = g_stage[k-1].g_fwd.r_a;
      assign w_b_rem   = g_stage[k-1].g_fwd.r_b;
      assign w_cin     = g_stage[k-1].r_carry;
      assign w_sum_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
    end

    assign w_seg = SEG1'(w_a_rem[SEG-1:0]) + SEG1'(w_b_rem[SEG-1:0]) + SEG1'(w_cin);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_adv) begin
        r_sum   <= w_sum_nxt;
        r_carry <= w_seg[SEG];
      end
    end

    // Upper operand bits ride along until their segment's stage.
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_rem[REM-1:SEG];
          r_b <= w_b_rem[REM-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic w_ovf;
      logic r_ovf;

      // Carry into MSB recovered from the MSB sum bit, XORed with carry out.
      assign w_ovf = w_a_rem[SEG-1] ^ w_b_rem[SEG-1] ^ w_seg[SEG-1] ^ w_seg[SEG];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign bus.ready_o    = w_ready;
  assign bus.valid_o    = r_valid[STAGES-1];
  assign bus.sum_o      = g_stage[STAGES-1].r_sum;
  assign bus.carry_o    = g_stage[STAGES-1].r_carry;
  assign bus.overflow_o = g_stage[STAGES-1].g_out.r_ovf;
  assign bus.zero_o     = ~|g_stage[STAGES-1].r_sum;
endmodule
